floo_wormhole_arbiter: RTL and testbench

FLOO_WORMHOLE_ARBITER -- requirements
Module: floo_wormhole_arbiter

---
 rtl/floo_pkg.sv | 16 +
 rtl/floo_rr_pick.sv | 30 +++
 rtl/floo_wormhole_arbiter.sv | 125 ++++++++++++
 tb/tb_floo_wormhole_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// Shared types and helpers for the wormhole arbiter.
// Contents: floo_wh_arb_state_e (IDLE / LOCKED) and floo_wrap_inc, a modulo-n increment.
// Ports: none (package).
package floo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } floo_wh_arb_state_e;

  // Increment an index and wrap from n-1 back to 0.
  function automatic int unsigned floo_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/floo_rr_pick.sv
// Rotating-priority picker: returns the first set request, searching from i_ptr upward with wrap.
// Ports: i_valid (NumInp request bits), i_ptr (start index); o_idx (winner, or i_ptr when none), o_any.
// Purely combinational, zero latency, no backpressure of its own.
module floo_rr_pick #(
  parameter int unsigned NumInp = 4,
  parameter int unsigned IdxW   = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic [NumInp-1:0] i_valid,
  input  logic [IdxW-1:0]   i_ptr,
  output logic [IdxW-1:0]   o_idx,
  output logic              o_any
);

  int unsigned w_j;

  always_comb begin
    o_idx = i_ptr;
    o_any = 1'b0;
    w_j   = 0;
    // Visit ptr, ptr+1, ... (mod NumInp); the first hit wins.
    for (int unsigned k = 0; k < NumInp; k++) begin
      w_j = (32'(i_ptr) + k) % NumInp;
      if (!o_any && i_valid[IdxW'(w_j)]) begin
        o_idx = IdxW'(w_j);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// Wormhole arbiter: round-robin picks an input at each packet head, then stays locked on it until
// its tail flit handshakes. Zero-latency combinational datapath; only the selected input sees ready.
// Ports: clk_i, rst_i (async, active-high); per-input valid_i/ready_o/data_i/last_i; output
// valid_o/ready_i/data_o/last_o; sel_o (forwarded index); locked_o (mid-packet);
// pkt_cnt_o (per-input completed packets, only when FLOO_WH_ARB_STATS_EN is defined).
module floo_wormhole_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumInp-1:0]                  valid_i,
  output logic [NumInp-1:0]                  ready_o,
  input  logic [NumInp-1:0][DataWidth-1:0]   data_i,
  input  logic [NumInp-1:0]                  last_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DataWidth-1:0]               data_o,
  output logic                               last_o,
  output logic [$clog2(NumInp)-1:0]          sel_o,
  output logic                               locked_o
`ifdef FLOO_WH_ARB_STATS_EN
  ,
  output logic [NumInp-1:0][CntWidth-1:0]    pkt_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(NumInp);

  floo_wh_arb_state_e r_state, w_state_nxt;
  logic [IdxW-1:0]    r_ptr, w_ptr_nxt;
  logic [IdxW-1:0]    r_lock, w_lock_nxt;

  logic [IdxW-1:0]    w_pick_idx;
  logic               w_pick_any;
  logic [IdxW-1:0]    w_sel;
  logic               w_hs;

  floo_rr_pick #(
    .NumInp (NumInp),
    .IdxW   (IdxW)
  ) u_pick (
    .i_valid (valid_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Once locked, the winner is frozen so no other input can interleave into the packet.
  assign w_sel = (r_state == LOCKED) ? r_lock : w_pick_idx;
  assign w_hs  = valid_o & ready_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock;
    unique case (r_state)
      IDLE: begin
        if (valid_o) begin
          if (w_hs && last_o) begin
            // Single-flit packet completes in one cycle; no need to lock.
            w_ptr_nxt = IdxW'(floo_wrap_inc(32'(w_sel), NumInp));
          end else begin
            // A stalled head locks too: the valid-stable rule guarantees it stays put.
            w_state_nxt = LOCKED;
            w_lock_nxt  = w_sel;
          end
        end
      end
      LOCKED: begin
        if (w_hs && last_o) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = IdxW'(floo_wrap_inc(32'(r_lock), NumInp));
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    valid_o  = valid_i[w_sel];
    data_o   = data_i[w_sel];
    last_o   = last_i[w_sel];
    sel_o    = w_sel;
    locked_o = (r_state == LOCKED);
    ready_o  = '0;
    // With nothing requesting in IDLE, sel only reports the pointer; keep all readies low.
    if (r_state == LOCKED || w_pick_any) begin
      ready_o[w_sel] = ready_i;
    end
  end

`ifdef FLOO_WH_ARB_STATS_EN
  logic [NumInp-1:0][CntWidth-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_hs && last_o && (r_cnt[w_sel] != {CntWidth{1'b1}})) begin
      r_cnt[w_sel] <= r_cnt[w_sel] + CntWidth'(1);
    end
  end

  assign pkt_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
module tb_floo_wormhole_arbiter;

  localparam int NI = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic                  clk;
  logic                  rst_i;
  logic [NI-1:0]         valid_i;
  logic [NI-1:0]         ready_o;
  logic [NI-1:0][DW-1:0] data_i;
  logic [NI-1:0]         last_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DW-1:0]         data_o;
  logic                  last_o;
  logic [1:0]            sel_o;
  logic                  locked_o;
`ifdef FLOO_WH_ARB_STATS_EN
  logic [NI-1:0][CW-1:0] pkt_cnt_o;
`endif

  floo_wormhole_arbiter #(
    .NumInp    (NI),
    .DataWidth (DW),
    .CntWidth  (CW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .last_i   (last_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .last_o   (last_o),
    .sel_o    (sel_o),
    .locked_o (locked_o)
`ifdef FLOO_WH_ARB_STATS_EN
    ,
    .pkt_cnt_o(pkt_cnt_o)
`endif
  );

  typedef struct packed {
    logic [1:0]    sel;
    logic [DW-1:0] dat;
    logic          last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [3:0] mon_rdy;
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.sel  = s;
    e.dat  = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got sel %0d data %0h, expected no output", sel_o, data_o);
      end else begin
        mon_e   = q.pop_front();
        mon_rdy = 4'b0001 << mon_e.sel;
        chk("sb_sel",   32'(sel_o),   32'(mon_e.sel));
        chk("sb_data",  32'(data_o),  32'(mon_e.dat));
        chk("sb_last",  32'(last_o),  32'(mon_e.last));
        chk("sb_ready", 32'(ready_o), 32'(mon_rdy));
      end
    end
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = '0;
    last_i  = '0;
    data_i  = '0;
    ready_i = 1'b0;
    #3;
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_sel",    32'(sel_o),    0);
    chk("rst_valid",  32'(valid_o),  0);
    chk("rst_ready",  32'(ready_o),  0);
    step(2);
    rst_i = 1'b0;
    step(1);

    // Round robin over four single-flit requesters.
    valid_i = 4'b1111;
    last_i  = 4'b1111;
    ready_i = 1'b1;
    for (int i = 0; i < NI; i++) begin
      data_i[i] = 16'h1000 + 16'(i);
      push(2'(i), 16'h1000 + 16'(i), 1'b1);
    end
    step(4);
    valid_i = '0;
    #1;
    chk("rr_ptr_wrap", 32'(sel_o),   0);
    chk("rr_idle",     32'(locked_o), 0);
    chk("idle_ready",  32'(ready_o),  0);

    // Move ptr to 2 with a single flit on input 1.
    valid_i   = 4'b0010;
    data_i[1] = 16'h2001;
    push(2'd1, 16'h2001, 1'b1);
    step(1);

    // Three-flit packet on input 2 while input 0 waits.
    valid_i   = 4'b0101;
    last_i    = 4'b0001;
    data_i[0] = 16'h3000;
    data_i[2] = 16'h3201;
    push(2'd2, 16'h3201, 1'b0);
    step(1);
    chk("pkt_locked", 32'(locked_o), 1);
    chk("pkt_sel",    32'(sel_o),    2);
    data_i[2] = 16'h3202;
    push(2'd2, 16'h3202, 1'b0);
    step(1);
    chk("pkt_hold_sel", 32'(sel_o), 2);
    data_i[2] = 16'h3203;
    last_i    = 4'b0101;
    push(2'd2, 16'h3203, 1'b1);
    step(1);
    valid_i = 4'b0001;
    #1;
    chk("pkt_after_sel",    32'(sel_o),    0);
    chk("pkt_after_locked", 32'(locked_o), 0);
    push(2'd0, 16'h3000, 1'b1);
    step(1);
    valid_i = '0;

    // ptr=1 now; a flit on input 2 moves it to 3.
    valid_i   = 4'b0100;
    data_i[2] = 16'h4002;
    push(2'd2, 16'h4002, 1'b1);
    step(1);
    // ptr=3, only input 1 valid: search 3,0,1.
    valid_i   = 4'b0010;
    last_i    = 4'b1111;
    data_i[1] = 16'h5001;
    #1;
    chk("wrap_sel", 32'(sel_o), 1);
    push(2'd1, 16'h5001, 1'b1);
    step(1);
    valid_i = '0;
    #1;
    chk("wrap_ptr", 32'(sel_o), 2);

    // Stalled head on input 1 locks, input 0 must not get in.
    ready_i   = 1'b0;
    valid_i   = 4'b0010;
    data_i[1] = 16'h6001;
    step(5);
    chk("stall_locked", 32'(locked_o), 1);
    chk("stall_sel",    32'(sel_o),    1);
    valid_i   = 4'b0011;
    data_i[0] = 16'h6000;
    #1;
    chk("stall_sel2",  32'(sel_o),   1);
    chk("stall_ready", 32'(ready_o), 0);
    chk("stall_valid", 32'(valid_o), 1);
    ready_i = 1'b1;
    #1;
    chk("stall_ready1", 32'(ready_o), 32'h2);
    push(2'd1, 16'h6001, 1'b1);
    step(1);
    chk("stall_next_sel",   32'(sel_o),   0);
    chk("stall_next_ready", 32'(ready_o), 32'h1);
    push(2'd0, 16'h6000, 1'b1);
    step(1);
    valid_i = '0;

    // ptr=1. Lock on input 3, then reset mid-packet.
    valid_i   = 4'b1000;
    last_i    = 4'b0000;
    data_i[3] = 16'h7301;
    push(2'd3, 16'h7301, 1'b0);
    step(1);
    data_i[3] = 16'h7302;
    push(2'd3, 16'h7302, 1'b0);
    step(1);
    chk("pre_rst_locked", 32'(locked_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_locked", 32'(locked_o), 0);
    valid_i = '0;
    #1;
    chk("arst_sel",   32'(sel_o),   0);
    chk("arst_valid", 32'(valid_o), 0);
`ifdef FLOO_WH_ARB_STATS_EN
    chk("arst_cnt", 32'(pkt_cnt_o), 0);
`endif
    step(1);
    rst_i = 1'b0;
    step(1);

    // Five single-flit packets from input 0.
    valid_i = 4'b0001;
    last_i  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      data_i[0] = 16'h8000 + 16'(k);
      push(2'd0, 16'h8000 + 16'(k), 1'b1);
      step(1);
    end
    valid_i = '0;
    #1;
`ifdef FLOO_WH_ARB_STATS_EN
    chk("cnt_sat0",  32'(pkt_cnt_o[0]), 3);
    chk("cnt_other", 32'({pkt_cnt_o[3], pkt_cnt_o[2], pkt_cnt_o[1]}), 0);
`endif
    chk("final_sel", 32'(sel_o), 1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("sb_drain", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
